buffer_register_serializer: RTL and testbench

Downstream stage of the buffer register. It captures one 13-bit syllable and its parity bit in parallel from the BRx bit lines on a load strobe. It then shifts the syllable out serially, LSB first, one bit per bit-time strobe to the serial arithmetic path. While shifting it accumulates syllable parity and reports a parity error when the syllable is complete.

---
 rtl/buffer_register_serializer.sv | 103 ++++++++++
 tb/tb_buffer_register_serializer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/buffer_register_serializer.sv
// Buffer register serializer: parallel capture of one syllable, LSB-first serial shift-out, parity check.
// Optional parity checking is built when BUFFER_REGISTER_SERIALIZER_PARITY_CHECK_EN is defined.
module buffer_register_serializer #(
  parameter int WIDTH = 13,
  parameter int ODD   = 1
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             LOAD,
  input  logic             BIT_STB,
  input  logic [WIDTH-1:0] BRx,
  input  logic             BRxP,
  input  logic             PERR_CLR,
  output logic             SER_DATA,
  output logic             SER_VALID,
  output logic             BUSY,
  output logic             DONE,
  output logic             PERR,
  output logic             LOAD_ERR
);

  localparam int   CW    = $clog2(WIDTH + 1);
  localparam logic ODD_B = 1'(ODD);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             load_ok;
  logic             shift_en;
  logic             last_bit;

  assign load_ok  = (state == IDLE) && LOAD;
  assign shift_en = (state == SHIFT) && BIT_STB;
  assign last_bit = shift_en && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (LOAD) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Everything below is decoded from registered state, so no input feeds an output directly.
  always_comb begin
    SER_VALID = (state == SHIFT);
    SER_DATA  = (state == SHIFT) ? shreg[0] : 1'b0;
    BUSY      = (state != IDLE);
    DONE      = (state == CHECK);
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load_ok) begin
      shreg <= BRx;
      cnt   <= '0;
    end else if (shift_en) begin
      shreg <= shreg >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

  // A set event in the same cycle as PERR_CLR takes priority.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST)                      LOAD_ERR <= 1'b0;
    else if (LOAD && state != IDLE)   LOAD_ERR <= 1'b1;
    else if (PERR_CLR)                LOAD_ERR <= 1'b0;
  end

`ifdef BUFFER_REGISTER_SERIALIZER_PARITY_CHECK_EN
  logic acc;

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST)       acc <= 1'b0;
    else if (load_ok)  acc <= BRxP;
    else if (shift_en) acc <= acc ^ shreg[0];
  end

  // The final bit is folded in here so PERR becomes visible together with DONE.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST)                                   PERR <= 1'b0;
    else if (last_bit && ((acc ^ shreg[0]) ^ ODD_B)) PERR <= 1'b1;
    else if (PERR_CLR)                             PERR <= 1'b0;
  end
`else
  logic unused_parity;

  assign unused_parity = ^{BRxP, ODD_B};
  assign PERR          = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_register_serializer.sv
// Bench for buffer_register_serializer: directed cases then random traffic vs a bit-queue reference model.
module tb_buffer_register_serializer;

  localparam int W   = 13;
  localparam int ODD = 1;
`ifdef BUFFER_REGISTER_SERIALIZER_PARITY_CHECK_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic         SIM_CLK = 1'b0;
  logic         SIM_RST, LOAD, BIT_STB, BRxP, PERR_CLR;
  logic [W-1:0] BRx;
  logic         SER_DATA, SER_VALID, BUSY, DONE, PERR, LOAD_ERR;

  buffer_register_serializer #(.WIDTH(W), .ODD(ODD)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .LOAD(LOAD), .BIT_STB(BIT_STB),
    .BRx(BRx), .BRxP(BRxP), .PERR_CLR(PERR_CLR),
    .SER_DATA(SER_DATA), .SER_VALID(SER_VALID), .BUSY(BUSY), .DONE(DONE),
    .PERR(PERR), .LOAD_ERR(LOAD_ERR)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  int n_chk = 0;
  int n_bad = 0;
  int n_done = 0;

  // Reference model: pending serial bits, a one-cycle check flag and the sticky flags.
  bit mq[$];
  bit m_chk, m_perr, m_lerr, m_err_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit ld, input bit stb, input logic [W-1:0] brx, input bit brxp,
                      input bit clr, input bit rst);
    bit busy_m, sp, sl;
    SIM_RST = rst; LOAD = ld; BIT_STB = stb; BRx = brx; BRxP = brxp; PERR_CLR = clr;
    @(posedge SIM_CLK);
    busy_m = (mq.size() > 0) || m_chk;
    if (rst) begin
      mq.delete(); m_chk = 0; m_perr = 0; m_lerr = 0;
    end else begin
      sp = 0;
      sl = ld && busy_m;
      if (m_chk) m_chk = 0;
      else if (mq.size() > 0) begin
        if (stb) begin
          void'(mq.pop_front());
          if (mq.size() == 0) begin
            m_chk = 1;
            sp = PEN && m_err_pend;
          end
        end
      end else if (ld) begin
        for (int i = 0; i < W; i++) mq.push_back(brx[i]);
        m_err_pend = ((($countones(brx) + int'(brxp)) % 2) != ODD);
      end
      m_perr = sp ? 1'b1 : (clr ? 1'b0 : m_perr);
      m_lerr = sl ? 1'b1 : (clr ? 1'b0 : m_lerr);
    end
    #1;
    chk("ser_valid", SER_VALID, mq.size() > 0);
    chk("ser_data",  SER_DATA,  (mq.size() > 0) ? mq[0] : 1'b0);
    chk("busy",      BUSY,      (mq.size() > 0) || m_chk);
    chk("done",      DONE,      m_chk);
    chk("perr",      PERR,      m_perr);
    chk("load_err",  LOAD_ERR,  m_lerr);
    if (DONE === 1'b1) n_done++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) step(0, 1, '0, 0, 0, 0);
  endtask

  initial begin
    int d0, lat;
    logic [W-1:0] r;

    step(0, 0, '0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 1);
    idle(1);

    // Alternating pattern, good odd parity, exactly one DONE.
    d0 = n_done;
    step(1, 0, 13'h1555, 0, 0, 0);
    strobes(W);
    idle(2);
    chk("done_once", n_done - d0, 1);

    // Bad parity, PERR sticks through a good syllable, then clears.
    step(1, 0, 13'h0003, 0, 0, 0);
    strobes(W);
    idle(1);
    chk("perr_bad", PERR, PEN);
    step(1, 0, 13'h1555, 0, 0, 0);
    strobes(W);
    idle(1);
    chk("perr_sticky", PERR, PEN);
    step(0, 0, '0, 0, 1, 0);
    chk("perr_clr", PERR, 0);

    // LOAD during shift is rejected and does not disturb the data.
    step(1, 0, 13'h0a5c, 1, 0, 0);
    strobes(5);
    step(1, 0, 13'h1fff, 1, 0, 0);
    strobes(8);
    idle(2);
    step(0, 0, '0, 0, 1, 0);

    // Reset mid-shift discards the syllable, then a fresh load works.
    d0 = n_done;
    step(1, 0, 13'h1234, 0, 0, 0);
    strobes(6);
    step(0, 0, '0, 0, 0, 1);
    idle(2);
    chk("rst_no_done", n_done - d0, 0);
    step(1, 0, 13'h0f0f, 1, 0, 0);
    strobes(W);
    idle(1);

    // Continuous strobe: DONE on the 14th sample counting from the load edge.
    step(1, 1, 13'h0789, 0, 0, 0);
    lat = 1;
    while (DONE !== 1'b1 && lat < 40) begin
      step(0, 1, '0, 0, 0, 0);
      lat++;
    end
    chk("done_latency", lat, 14);

    // LOAD together with DONE is rejected, the next cycle is accepted.
    step(1, 0, 13'h1111, 1, 0, 0);
    chk("b2b_lerr", LOAD_ERR, 1);
    step(1, 0, 13'h0ace, 0, 0, 0);
    chk("b2b_accept", SER_VALID, 1);
    strobes(W);
    idle(1);
    step(1, 0, '0, 0, 1, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r = W'($urandom);
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1), r, 1'($urandom),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
